// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life board sequencer.
//   ROWS/ROW_W : board geometry (8x8, one byte per row)
//   row_t      : one board row
//   addr_t     : row index; 3-bit arithmetic gives the toroidal mod-8 wrap for free
//   seq_state_t: sequencer state
package life_pkg;
  localparam int ROWS   = 8;
  localparam int ROW_W  = 8;
  localparam int ADDR_W = 3;

  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    DISPLAY = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2
  } seq_state_t;
endpackage

// File: rtl/life_shadow_buf.sv
// Shadow copy of the board used during an update pass.
// Writes land at waddr on the rising edge; reads are combinational and return
// the centre row at raddr plus its toroidal neighbours above and below.
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write row index
//   wdata  in  write row data
//   raddr  in  centre row index
//   row_c  out shadow[raddr]
//   row_a  out shadow[(raddr-1) mod 8]
//   row_b  out shadow[(raddr+1) mod 8]
module life_shadow_buf
  import life_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  row_t  wdata,
  input  addr_t raddr,
  output row_t  row_c,
  output row_t  row_a,
  output row_t  row_b
);
  row_t  cells [ROWS];
  addr_t addr_a;
  addr_t addr_b;

  always_ff @(posedge clk) begin
    if (we) cells[waddr] <= wdata;
  end

  // 3-bit wrap-around implements the torus vertically.
  assign addr_a = raddr - 3'd1;
  assign addr_b = raddr + 3'd1;

  assign row_c = cells[raddr];
  assign row_a = cells[addr_a];
  assign row_b = cells[addr_b];
endmodule

// File: rtl/life_sequencer.sv
// Board memory sequencer: arbitrates the 8x8 board memory between the LED
// display scan, host row writes and the generation update pass.
//   ph1            in  system clock (rising edge)
//   reset          in  synchronous active-high reset
//   run_en         in  automatic generation every FRAMES_PER_GEN frames
//   step           in  pulse: one generation at the next frame boundary
//   host_we/addr/wdata in  host row write (held until host_ready)
//   host_ready     out host write accepted this cycle
//   mem_addr/we/wdata  out board memory port; mem_rdata in (combinational)
//   dec_row_in/a/b out  rows fed to the external decoder (0 outside COMPUTE)
//   dec_row_out    in  decoder next-generation centre row
//   disp_addr/row/valid out registered row for the display controller
//   busy           out update pass in progress
//   gen_done       out pulse after the last write-back of a pass
//   gen_count      out completed generations (wrapping)
module life_sequencer
  import life_pkg::*;
#(
  parameter int FRAMES_PER_GEN = 64,
  parameter int GEN_CNT_W      = 16
) (
  input  logic                 ph1,
  input  logic                 reset,
  input  logic                 run_en,
  input  logic                 step,
  input  logic                 host_we,
  input  logic [2:0]           host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_ready,
  output logic [2:0]           mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic [7:0]           dec_row_in,
  output logic [7:0]           dec_row_a,
  output logic [7:0]           dec_row_b,
  input  logic [7:0]           dec_row_out,
  output logic [2:0]           disp_addr,
  output logic [7:0]           disp_row,
  output logic                 disp_valid,
  output logic                 busy,
  output logic                 gen_done,
  output logic [GEN_CNT_W-1:0] gen_count
);
  localparam logic [7:0] FC_LAST = 8'(FRAMES_PER_GEN - 1);

  seq_state_t state, state_n;
  addr_t      disp_ptr;
  addr_t      pass_ptr;   // ld_ptr in LOAD, r in COMPUTE
  logic [7:0] frame_cnt;
  logic       step_pend;

  logic rd_cycle;
  logic boundary;
  logic trigger;
  logic sh_we;
  row_t sh_c, sh_a, sh_b;

  life_shadow_buf u_shadow (
    .clk   (ph1),
    .we    (sh_we),
    .waddr (pass_ptr),
    .wdata (mem_rdata),
    .raddr (pass_ptr),
    .row_c (sh_c),
    .row_a (sh_a),
    .row_b (sh_b)
  );

  assign busy = (state != DISPLAY);

  always_comb begin
    state_n    = state;
    mem_addr   = disp_ptr;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    host_ready = 1'b0;
    rd_cycle   = 1'b0;
    boundary   = 1'b0;
    trigger    = 1'b0;
    sh_we      = 1'b0;
    dec_row_in = '0;
    dec_row_a  = '0;
    dec_row_b  = '0;
    case (state)
      DISPLAY: begin
        if (host_we) begin
          // Host write steals the cycle; a boundary due now slips by one.
          mem_addr   = host_addr;
          mem_we     = 1'b1;
          mem_wdata  = host_wdata;
          host_ready = 1'b1;
        end else begin
          rd_cycle = 1'b1;
          boundary = (disp_ptr == 3'd7);
          trigger  = boundary && (step_pend || (run_en && frame_cnt == FC_LAST));
          if (trigger) state_n = LOAD;
        end
      end
      LOAD: begin
        mem_addr = pass_ptr;
        sh_we    = 1'b1;
        if (pass_ptr == 3'd7) state_n = COMPUTE;
      end
      COMPUTE: begin
        // Reads come from the shadow copy, so in-order write-back is safe.
        mem_addr   = pass_ptr;
        mem_we     = 1'b1;
        mem_wdata  = dec_row_out;
        dec_row_in = sh_c;
        dec_row_a  = sh_a;
        dec_row_b  = sh_b;
        if (pass_ptr == 3'd7) state_n = DISPLAY;
      end
      default: state_n = DISPLAY;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state      <= DISPLAY;
      disp_ptr   <= '0;
      pass_ptr   <= '0;
      frame_cnt  <= '0;
      step_pend  <= 1'b0;
      gen_count  <= '0;
      gen_done   <= 1'b0;
      disp_valid <= 1'b0;
      disp_addr  <= '0;
      disp_row   <= '0;
    end else begin
      state      <= state_n;
      gen_done   <= 1'b0;
      disp_valid <= rd_cycle;

      if (rd_cycle) begin
        disp_addr <= disp_ptr;
        disp_row  <= mem_rdata;
        disp_ptr  <= disp_ptr + 3'd1;
      end

      // frame_cnt stops at the last value so run_en fires at the next boundary.
      if (boundary) begin
        if (trigger)                 frame_cnt <= '0;
        else if (frame_cnt != FC_LAST) frame_cnt <= frame_cnt + 8'd1;
      end

      // A step landing on the trigger cycle is absorbed into this pass.
      if (trigger)   step_pend <= 1'b0;
      else if (step) step_pend <= 1'b1;

      if (trigger)              pass_ptr <= '0;
      else if (state != DISPLAY) pass_ptr <= pass_ptr + 3'd1;

      if (state == COMPUTE && pass_ptr == 3'd7) begin
        gen_done  <= 1'b1;
        gen_count <= gen_count + 1'b1;
        disp_ptr  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_life_sequencer.sv
module tb_life_sequencer;
  import life_pkg::*;

  localparam int FPG = 2;

  typedef logic [ROWS-1:0][ROW_W-1:0] board_t;
  typedef struct {
    board_t board;
    int     gen;
  } sb_ent_t;

  logic        ph1 = 1'b0;
  logic        reset, run_en, step, host_we;
  logic [2:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_ready, mem_we, disp_valid, busy, gen_done;
  logic [2:0]  mem_addr, disp_addr;
  logic [7:0]  mem_wdata, mem_rdata, dec_row_in, dec_row_a, dec_row_b, dec_row_out, disp_row;
  logic [15:0] gen_count;

  board_t  mem;       // board memory model
  board_t  golden;    // expected memory contents
  sb_ent_t sb[$];     // expected result of each pending pass
  int      n_chk = 0, n_err = 0;
  int      gen_seen = 0, exp_gen = 0, cyc = 0, last_gd = 0;

  always #5 ph1 = ~ph1;

  life_sequencer #(.FRAMES_PER_GEN(FPG), .GEN_CNT_W(16)) dut (
    .ph1(ph1), .reset(reset), .run_en(run_en), .step(step),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dec_row_in(dec_row_in), .dec_row_a(dec_row_a), .dec_row_b(dec_row_b), .dec_row_out(dec_row_out),
    .disp_addr(disp_addr), .disp_row(disp_row), .disp_valid(disp_valid),
    .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
  );

  always @(posedge ph1) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Toroidal life rule for one row (decoder_top stand-in and golden model).
  function automatic row_t life_row(input row_t a, input row_t c, input row_t b);
    row_t n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      int l, r, s;
      l = (i + 7) % 8;
      r = (i + 1) % 8;
      s = int'(a[l]) + int'(a[i]) + int'(a[r]) + int'(c[l]) + int'(c[r])
        + int'(b[l]) + int'(b[i]) + int'(b[r]);
      n[i] = (s == 3) || (c[i] && s == 2);
    end
    return n;
  endfunction

  function automatic board_t next_board(input board_t g);
    board_t nb;
    for (int r = 0; r < 8; r++) nb[r] = life_row(g[(r + 7) % 8], g[r], g[(r + 1) % 8]);
    return nb;
  endfunction

  assign dec_row_out = life_row(dec_row_a, dec_row_in, dec_row_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: per-cycle checks at the falling edge, return at posedge+1.
  task automatic tick();
    sb_ent_t e;
    @(negedge ph1);
    cyc++;
    if (!reset) begin
      if (disp_valid) chk("disp_row", disp_row, golden[disp_addr]);
      if (!busy) chk("dec_idle", {8'h0, dec_row_a, dec_row_in, dec_row_b}, 0);
      else       chk("busy_no_ready", host_ready, 0);
      if (gen_done) begin
        gen_seen++;
        if (sb.size() == 0) chk("unexp_gen_done", 1, 0);
        else begin
          e = sb.pop_front();
          for (int r = 0; r < 8; r++) chk("board_row", mem[r], e.board[r]);
          chk("gen_count", gen_count, e.gen);
          golden  = e.board;
          last_gd = cyc;
        end
      end
    end
    @(posedge ph1);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input row_t d);
    int n;
    n = 0;
    host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    while (!host_ready && n < 64) begin tick(); n++; end
    chk("host_ready", host_ready, 1);
    tick();
    host_we = 1'b0;
    golden[a] = d;
  endtask

  task automatic do_step();
    exp_gen++;
    sb.push_back('{board: next_board(golden), gen: exp_gen});
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic wait_gen(input int limit);
    int n0, k;
    n0 = gen_seen;
    k  = 0;
    while (gen_seen == n0 && k < limit) begin tick(); k++; end
    chk("gen_timeout", 32'(gen_seen != n0), 1);
  endtask

  task automatic wait_busy();
    int k;
    k = 0;
    while (!busy && k < 40) begin tick(); k++; end
    chk("busy_rise", busy, 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_valid", disp_valid, 0);
    chk("rst_addr", disp_addr, 0);
    chk("rst_row", disp_row, 0);
    chk("rst_gdone", gen_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_gcount", gen_count, 0);
  endtask

  initial begin
    board_t b;
    int     gd [4];
    reset = 1'b1; run_en = 1'b0; step = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; golden = '0;
    @(posedge ph1); #1;
    repeat (2) tick();
    chk_reset_outs();

    // Clear the board, then reset again for the scan test.
    reset = 1'b0;
    for (int r = 0; r < 8; r++) host_write(3'(r), 8'h00);
    reset = 1'b1;
    repeat (2) tick();
    chk_reset_outs();

    // 1: display scan, no passes with run_en=0
    reset = 1'b0;
    chk("t1_valid0", disp_valid, 0);
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("t1_valid", disp_valid, 1);
      chk("t1_addr", disp_addr, 32'(i % 8));
      chk("t1_busy", busy, 0);
    end

    // 2: horizontal blinker, single step
    host_write(3'd3, 8'b0001_1100);
    do_step();
    wait_gen(200);
    for (int r = 0; r < 8; r++)
      chk("t2_row", mem[r], (r >= 2 && r <= 4) ? 32'h08 : 32'h00);
    chk("t2_gcount", gen_count, 1);

    // 5: host write held through COMPUTE
    do_step();
    wait_busy();
    repeat (10) tick();
    host_we = 1'b1; host_addr = 3'd0; host_wdata = 8'h81;
    #1;
    for (int k = 0; k < 40 && busy; k++) begin
      chk("t5_hold", host_ready, 0);
      tick();
    end
    chk("t5_ready", host_ready, 1);
    chk("t5_gdone", gen_done, 1);
    tick();
    host_we = 1'b0;
    golden[0] = 8'h81;
    chk("t5_blank", disp_valid, 0);
    tick();
    chk("t5_valid", disp_valid, 1);
    chk("t5_addr", disp_addr, 0);

    // 3: blinker under run_en, one pass per 2 frames
    for (int r = 0; r < 8; r++) host_write(3'(r), (r == 3) ? 8'h1C : 8'h00);
    b = golden;
    for (int i = 0; i < 4; i++) begin
      b = next_board(b);
      exp_gen++;
      sb.push_back('{board: b, gen: exp_gen});
    end
    run_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gen(300);
      gd[i] = last_gd;
    end
    run_en = 1'b0;
    for (int i = 1; i < 4; i++) chk("t3_period", 32'(gd[i] - gd[i-1]), 32);
    chk("t3_row3", mem[3], 8'h1C);

    // 4: glider across both wrap edges, 4 generations
    for (int r = 0; r < 8; r++)
      host_write(3'(r), (r == 0) ? 8'h83 : (r == 6) ? 8'h01 : (r == 7) ? 8'h02 : 8'h00);
    for (int i = 0; i < 4; i++) begin
      do_step();
      wait_gen(200);
    end
    for (int r = 0; r < 8; r++)
      chk("t4_row", mem[r], (r == 7) ? 32'h02 : (r == 0) ? 32'h04 : (r == 1) ? 32'h07 : 32'h00);

    // 6: reset in COMPUTE before row 4 is written
    for (int r = 0; r < 8; r++) host_write(3'(r), (r == 1 || r == 5) ? 8'h1C : 8'h00);
    b = next_board(golden);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_busy();
    repeat (11) tick();
    reset = 1'b1;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_gcount", gen_count, 0);
    chk("t6_gdone", gen_done, 0);
    exp_gen = 0;
    for (int r = 0; r < 4; r++) golden[r] = b[r];
    for (int r = 0; r < 8; r++)
      chk("t6_row", mem[r], (r <= 2) ? 32'h08 : (r == 5) ? 32'h1C : 32'h00);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("t6_idle", busy, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
